// File: rtl/sniffer_pkg.sv
// Shared definitions for the capture-path writer: writer states and the
// xorshift16 test-pattern generator step.
package sniffer_pkg;

    // Seed of the test-pattern generator; every test run starts from here.
    localparam logic [15:0] RNG_SEED = 16'h6C41;

    // State encoding of the slave FIFO writer.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_TEST   = 2'd2;
    localparam logic [1:0] ST_PKTEND = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        STREAM = ST_STREAM,
        TEST   = ST_TEST,
        PKTEND = ST_PKTEND
    } writer_state_t;

    // One xorshift16 step: x ^= x << 7; x ^= x >> 9; x ^= x << 8.
    function automatic logic [15:0] rng_next(input logic [15:0] x);
        logic [15:0] y;
        y = x ^ (x << 7);
        y = y ^ (y >> 9);
        y = y ^ (y << 8);
        return y;
    endfunction

endpackage

// File: rtl/xorshift16_gen.sv
// Holds the test-pattern generator state; can be reloaded to the seed or
// advanced by one xorshift16 step per cycle.
module xorshift16_gen
    import sniffer_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        load_i,
    input  logic        step_i,
    output logic [15:0] value_o
);

    // Generator register: seed on reset or reload, otherwise step on request.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            value_o <= RNG_SEED;
        end else if (load_i) begin
            value_o <= RNG_SEED;
        end else if (step_i) begin
            value_o <= rng_next(value_o);
        end
    end

endmodule

// File: rtl/slave_fifo_writer.sv
// Drains capture words from the CDC FIFO into the USB controller slave FIFO,
// committing short packets with pktend on idle timeout or flush, or streams
// a xorshift16 pattern in test mode.
module slave_fifo_writer
    import sniffer_pkg::*;
#(
    parameter int W            = 16,
    parameter int PKT_WORDS    = 256,
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         test_i,
    input  logic         flush_i,
    input  logic [W-1:0] fifo_data_i,
    input  logic         fifo_valid_i,
    output logic         fifo_rd_o,
    input  logic         flagb_i,
    output logic         slwr_o,
    output logic         pktend_o,
    output logic [W-1:0] fd_o,
    output logic [31:0]  words_o
);

    localparam int PW = $clog2(PKT_WORDS);
    localparam int IW = $clog2(IDLE_TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    writer_state_t state;
    writer_state_t state_next;

    logic [PW-1:0] pkt_cnt;
    logic [IW-1:0] idle_cnt;
    logic          pend;
    logic [15:0]   rng_value;

    logic accept;
    logic test_write;
    logic timeout_hit;
    logic pend_set;
    logic pktend_fire;
    logic rng_load;

    xorshift16_gen u_rng (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (rng_load),
        .step_i    (test_write),
        .value_o   (rng_value)
    );

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control: a packet is committed only once no word
    // is being accepted, so the last accepted word's write always precedes pktend.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        test_write  = 1'b0;
        timeout_hit = 1'b0;
        pend_set    = 1'b0;
        pktend_fire = 1'b0;
        rng_load    = 1'b0;
        case (state)
            IDLE: begin
                state_next = test_i ? TEST : STREAM;
            end
            STREAM: begin
                accept      = fifo_valid_i && !flagb_i && !pend && !test_i;
                timeout_hit = (pkt_cnt != '0) && (idle_cnt == IDLE_LAST) && !accept;
                pend_set    = flush_i || timeout_hit;
                if (!accept) begin
                    if (pend || pend_set || (test_i && (pkt_cnt != '0))) begin
                        state_next = PKTEND;
                    end else if (test_i) begin
                        state_next = IDLE;
                    end
                end
            end
            TEST: begin
                if (!test_i) begin
                    state_next = IDLE;
                    rng_load   = 1'b1;
                end else begin
                    test_write = !flagb_i;
                end
            end
            PKTEND: begin
                if (!flagb_i) begin
                    pktend_fire = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign fifo_rd_o = accept;

    // Registered slave FIFO interface and running word count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slwr_o   <= 1'b0;
            pktend_o <= 1'b0;
            fd_o     <= '0;
            words_o  <= '0;
        end else begin
            slwr_o   <= accept || test_write;
            pktend_o <= pktend_fire;
            if (accept) begin
                fd_o <= fifo_data_i;
            end else if (test_write) begin
                fd_o <= W'(rng_next(rng_value));
            end
            if (accept || test_write) begin
                words_o <= words_o + 32'd1;
            end
        end
    end

    // Packet bookkeeping: word count within the packet, idle timer and pending commit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pkt_cnt  <= '0;
            idle_cnt <= '0;
            pend     <= 1'b0;
        end else begin
            if (pktend_fire) begin
                pkt_cnt <= '0;
            end else if (accept) begin
                pkt_cnt <= pkt_cnt + PW'(1);
            end

            if ((state != STREAM) || accept || (pkt_cnt == '0)) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_LAST) begin
                idle_cnt <= idle_cnt + IW'(1);
            end

            if (pktend_fire) begin
                pend <= 1'b0;
            end else if (pend_set) begin
                pend <= 1'b1;
            end
        end
    end

endmodule
